hazard_scheduler: RTL and testbench
===================================

Name: hazard_scheduler

Overview:
- Pipeline sequencing block for the 5-stage RV32I core; sits beside the stage-decode controller and the datapath.
- Generates operand forwarding selects, load-use stalls, branch/jump flushes and a data-memory wait freeze with a timeout watchdog.
- Keeps saturating stall and flush performance counters.
- All stall, flush and forward outputs are combinational from the current inputs and FSM state. Counters, FSM and error flag are registered.

Parameters:
- CNT_W, 16, width of performance counters.
- TIMEOUT, 15, maximum consecutive memory-wait cycles before the watchdog releases the pipeline (must be >= 1).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- Rs1D  input  5  source reg 1 of instruction in Decode
- Rs2D  input  5  source reg 2 of instruction in Decode
- Rs1E  input  5  source reg 1 in Execute
- Rs2E  input  5  source reg 2 in Execute
- RdE  input  5  destination in Execute
- RdM  input  5  destination in Memory
- RdW  input  5  destination in Writeback
- RegWriteM  input  1  Memory-stage register write enable
- RegWriteW  input  1  Writeback-stage register write enable
- ResultSrcE0  input  1  bit 0 of ResultSrcE; 1 = load in Execute
- PCSrcE  input  1  taken branch/jump resolved in Execute
- MemReqM  input  1  load/store active in Memory
- MemReadyM  input  1  data memory completes access this cycle
- ForwardAE  output  2  00 register file, 01 ResultW, 10 ALUResultM
- ForwardBE  output  2  same encoding for operand B
- StallF  output  1  hold PC
- StallD  output  1  hold IF/ID register
- StallE  output  1  hold ID/EX register
- StallM  output  1  hold EX/MEM register
- FlushD  output  1  clear IF/ID register
- FlushE  output  1  clear ID/EX register (bubble)
- FlushW  output  1  clear MEM/WB register
- MemErr  output  1  sticky watchdog timeout flag
- StallCnt  output  CNT_W  cycles with StallF=1
- FlushCnt  output  CNT_W  cycles with FlushD=1

Behaviour:
- Forwarding (per operand, shown for A; B identical using Rs2E):
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - else 00.
  - M has priority over W.
- Load-use:
  - lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- Freeze:
  - freeze = MemReqM & ~MemReadyM & state==WAITABLE.
  - While freeze: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - Freeze overrides load-use and branch; PCSrcE is held by the frozen stage and acts after release.
- Normal (no freeze):
  - StallF=StallD=lwStall & ~PCSrcE.
  - FlushD=PCSrcE.
  - FlushE=lwStall|PCSrcE.
  - StallE=StallM=FlushW=0.
  - Branch beats load-use because the stalled D instruction is squashed.
- FSM states:
  - RUN:
    - freeze condition → WAIT, wcnt<=1.
  - WAIT:
    - MemReadyM=1 or MemReqM=0 → RUN.
    - else if wcnt==TIMEOUT → BYPASS, MemErr<=1.
    - else wcnt++.
  - BYPASS:
    - freeze suppressed (state not WAITABLE); pipeline advances one cycle, then → RUN.
  - WAITABLE = RUN or WAIT.
- Counters:
  - Increment on the rising edge when the condition holds.
  - Saturate at all-ones, never wrap.
- Reset (synchronous):
  - state=RUN, wcnt=0, MemErr=0, StallCnt=FlushCnt=0.
  - While reset=1, outputs are forced: Forward*=00, all Stall*=0, FlushD=FlushE=FlushW=1.
  - Reset mid-WAIT abandons the access; no MemErr is set.
- MemErr is cleared only by reset.

Test Plan:
- RdM=5, RegWriteM=1, Rs1E=5; RdW=5, RegWriteW=1 → ForwardAE=10. Same with RdM=0 → ForwardAE=01. Rs2E=0 with RdW=0 → ForwardBE=00.
- Load in E (ResultSrcE0=1, RdE=7), Rs2D=7, PCSrcE=0 → StallF=StallD=FlushE=1, FlushD=0 for one cycle; StallCnt +1. Then raise PCSrcE=1 in the same cycle → StallF=0, FlushD=FlushE=1, FlushCnt +1.
- MemReqM=1, MemReadyM=0 for 3 cycles then 1 → StallF..StallM=1 and FlushW=1 for exactly 3 cycles, state returns to RUN, MemErr=0.
- TIMEOUT=4, MemReadyM held 0 → freeze for 5 cycles, MemErr=1, one unfrozen cycle, then freeze re-engages while MemReqM stays 1.
- Force StallCnt to all-ones-1, hold load-use 3 cycles → counter saturates at all-ones.
- Assert reset during WAIT → next cycle state RUN, MemErr=0, counters 0, FlushD/E/W=1 while reset held.

Source files
------------

// File: rtl/hazard_if.sv
// Signal bundle between the pipeline datapath/decode controller and hazard_scheduler.
// The master drives the stage fields; the slave (the scheduler) returns the control outputs.
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             ResultSrcE0;
    logic             PCSrcE;
    logic             MemReqM;
    logic             MemReadyM;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic             MemErr;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, MemErr, StallCnt, FlushCnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, MemErr, StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_scheduler.sv
// Hazard control for the 5-stage RV32I pipeline: forwarding, load-use stall, branch flush,
// data-memory wait freeze with watchdog, and saturating stall/flush counters.
//
// state     | meaning
// ST_RUN    | normal flow; a pending memory access with no ready freezes the pipe
// ST_WAIT   | pipe frozen on memory; wcnt counts frozen cycles toward TIMEOUT
// ST_BYPASS | watchdog fired; freeze suppressed for one cycle so the pipe advances
module hazard_scheduler #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic    clk,
    input  logic    reset,
    hazard_if.slave hz
);
    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_BYPASS = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lw_stall;
    logic freeze;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic rw_m,
                                           input logic [4:0] rd_m, input logic rw_w,
                                           input logic [4:0] rd_w);
        if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign lw_stall = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    assign freeze   = hz.MemReqM && !hz.MemReadyM &&
                      ((state_q == ST_RUN) || (state_q == ST_WAIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wcnt_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d = ST_WAIT;
                    wcnt_d  = WC_W'(1);
                end
            end
            ST_WAIT: begin
                if (hz.MemReadyM || !hz.MemReqM) begin
                    state_d = ST_RUN;
                end else if (wcnt_q == WC_W'(TIMEOUT)) begin
                    state_d   = ST_BYPASS;
                    mem_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WC_W'(1);
                end
            end
            ST_BYPASS: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // Counters track the final (post-override) StallF/FlushD values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (hz.FlushD && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
        hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
        hz.StallF    = lw_stall && !hz.PCSrcE;
        hz.StallD    = lw_stall && !hz.PCSrcE;
        hz.StallE    = 1'b0;
        hz.StallM    = 1'b0;
        hz.FlushD    = hz.PCSrcE;
        hz.FlushE    = lw_stall || hz.PCSrcE;
        hz.FlushW    = 1'b0;
        if (reset) begin
            hz.ForwardAE = 2'b00;
            hz.ForwardBE = 2'b00;
            hz.StallF    = 1'b0;
            hz.StallD    = 1'b0;
            hz.FlushD    = 1'b1;
            hz.FlushE    = 1'b1;
            hz.FlushW    = 1'b1;
        end else if (freeze) begin
            // The frozen stages hold PCSrcE, so a branch here resolves after release.
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushD = 1'b0;
            hz.FlushE = 1'b0;
            hz.FlushW = 1'b1;
        end
    end

    assign hz.MemErr   = mem_err_q;
    assign hz.StallCnt = stall_cnt_q;
    assign hz.FlushCnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed scenarios then random traffic, all outputs compared
// every cycle against a run-length/saturating-count model of the scheduling rules.
module tb_hazard_scheduler;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    hazard_if #(.CNT_W(CNT_W)) hif ();

    hazard_scheduler #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    int   m_run;     // consecutive frozen cycles in the current wait
    bit   m_bypass;  // this cycle is the watchdog release cycle
    bit   m_err;
    int   m_scnt;
    int   m_fcnt;
    bit   m_frz;
    logic [1:0] e_fa, e_fb;
    logic e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (hif.RegWriteM && hif.RdM != 0 && hif.RdM == rs) return 2'b10;
        if (hif.RegWriteW && hif.RdW != 0 && hif.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic eval();
        logic lw;
        #3;
        lw    = hif.ResultSrcE0 && hif.RdE != 0 && (hif.RdE == hif.Rs1D || hif.RdE == hif.Rs2D);
        m_frz = !reset && hif.MemReqM && !hif.MemReadyM && !m_bypass;
        if (reset) begin
            e_fa = 0; e_fb = 0;
            {e_sf, e_sd, e_se, e_sm} = 4'b0000;
            {e_fd, e_fe, e_fw} = 3'b111;
        end else if (m_frz) begin
            e_fa = ref_fwd(hif.Rs1E); e_fb = ref_fwd(hif.Rs2E);
            {e_sf, e_sd, e_se, e_sm} = 4'b1111;
            {e_fd, e_fe, e_fw} = 3'b001;
        end else begin
            e_fa = ref_fwd(hif.Rs1E); e_fb = ref_fwd(hif.Rs2E);
            e_sf = lw && !hif.PCSrcE; e_sd = e_sf; e_se = 0; e_sm = 0;
            e_fd = hif.PCSrcE; e_fe = lw || hif.PCSrcE; e_fw = 0;
        end
        chk("ForwardAE", 32'(hif.ForwardAE), 32'(e_fa));
        chk("ForwardBE", 32'(hif.ForwardBE), 32'(e_fb));
        chk("StallF", 32'(hif.StallF), 32'(e_sf));
        chk("StallD", 32'(hif.StallD), 32'(e_sd));
        chk("StallE", 32'(hif.StallE), 32'(e_se));
        chk("StallM", 32'(hif.StallM), 32'(e_sm));
        chk("FlushD", 32'(hif.FlushD), 32'(e_fd));
        chk("FlushE", 32'(hif.FlushE), 32'(e_fe));
        chk("FlushW", 32'(hif.FlushW), 32'(e_fw));
        chk("MemErr", 32'(hif.MemErr), 32'(m_err));
        chk("StallCnt", 32'(hif.StallCnt), 32'(m_scnt));
        chk("FlushCnt", 32'(hif.FlushCnt), 32'(m_fcnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_run = 0; m_bypass = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (e_sf && m_scnt < CMAX) m_scnt++;
            if (e_fd && m_fcnt < CMAX) m_fcnt++;
            if (m_bypass) begin
                m_bypass = 0; m_run = 0;
            end else if (m_frz) begin
                m_run++;
                if (m_run == TIMEOUT + 1) begin
                    m_bypass = 1; m_err = 1; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0;
        hif.RdE = 0; hif.RdM = 0; hif.RdW = 0;
        hif.RegWriteM = 0; hif.RegWriteW = 0; hif.ResultSrcE0 = 0;
        hif.PCSrcE = 0; hif.MemReqM = 0; hif.MemReadyM = 0;
    endtask

    initial begin
        int n;
        int prev;
        logic [7:0] pat;
        m_run = 0; m_bypass = 0; m_err = 0; m_scnt = 0; m_fcnt = 0; m_frz = 0;

        // reset with active-looking inputs: outputs forced
        reset = 1;
        idle_inputs();
        hif.PCSrcE = 1; hif.RegWriteM = 1; hif.RdM = 3; hif.Rs1E = 3;
        eval();
        chk("rst_ForwardAE", 32'(hif.ForwardAE), 0);
        chk("rst_FlushW", 32'(hif.FlushW), 1);
        tick();
        eval();
        tick();
        reset = 0;
        idle_inputs();

        // forwarding priority
        hif.Rs1E = 5; hif.RdM = 5; hif.RegWriteM = 1; hif.RdW = 5; hif.RegWriteW = 1;
        eval();
        chk("fwdA_mem_prio", 32'(hif.ForwardAE), 32'h2);
        tick();
        hif.RdM = 0;
        eval();
        chk("fwdA_wb", 32'(hif.ForwardAE), 32'h1);
        tick();
        hif.Rs2E = 0; hif.RdW = 0;
        eval();
        chk("fwdB_x0", 32'(hif.ForwardBE), 32'h0);
        tick();
        idle_inputs();

        // load-use, then load-use with branch
        hif.ResultSrcE0 = 1; hif.RdE = 7; hif.Rs2D = 7;
        prev = m_scnt;
        eval();
        chk("lu_StallF", 32'(hif.StallF), 1);
        chk("lu_FlushE", 32'(hif.FlushE), 1);
        chk("lu_FlushD", 32'(hif.FlushD), 0);
        tick();
        eval();
        chk("lu_StallCnt_inc", 32'(hif.StallCnt), 32'(prev + 1));
        hif.PCSrcE = 1;
        prev = m_fcnt;
        eval();
        chk("br_StallF", 32'(hif.StallF), 0);
        chk("br_FlushD", 32'(hif.FlushD), 1);
        chk("br_FlushE", 32'(hif.FlushE), 1);
        tick();
        eval();
        chk("br_FlushCnt_inc", 32'(hif.FlushCnt), 32'(prev + 1));
        tick();
        idle_inputs();

        // memory wait of 3 cycles then ready
        hif.MemReqM = 1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            hif.MemReadyM = (i == 3);
            eval();
            if (hif.StallM && hif.FlushW && hif.StallF) n++;
            tick();
        end
        hif.MemReqM = 0; hif.MemReadyM = 0;
        eval();
        chk("wait3_frozen_cycles", 32'(n), 3);
        chk("wait3_MemErr", 32'(hif.MemErr), 0);
        tick();

        // watchdog: 5 frozen, 1 released, then freeze again
        hif.MemReqM = 1; hif.MemReadyM = 0;
        for (int i = 0; i < 8; i++) begin
            eval();
            pat[i] = hif.StallM;
            if (i == 5) chk("wd_MemErr", 32'(hif.MemErr), 1);
            tick();
        end
        chk("wd_freeze_pattern", 32'(pat), 32'b11011111);

        // reset while waiting
        reset = 1;
        eval();
        chk("rstw_FlushD", 32'(hif.FlushD), 1);
        chk("rstw_FlushE", 32'(hif.FlushE), 1);
        chk("rstw_FlushW", 32'(hif.FlushW), 1);
        chk("rstw_StallF", 32'(hif.StallF), 0);
        tick();
        eval();
        chk("rstw_MemErr", 32'(hif.MemErr), 0);
        chk("rstw_StallCnt", 32'(hif.StallCnt), 0);
        tick();
        reset = 0;
        eval();
        chk("rstw_run_freeze", 32'(hif.StallM), 1);
        tick();
        idle_inputs();

        // saturation of StallCnt
        hif.ResultSrcE0 = 1; hif.RdE = 9; hif.Rs1D = 9;
        for (int i = 0; i < CMAX + 3; i++) begin
            eval();
            tick();
        end
        eval();
        chk("sat_StallCnt", 32'(hif.StallCnt), 32'(CMAX));
        tick();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 199) == 0);
            hif.Rs1D        = 5'($urandom_range(0, 3));
            hif.Rs2D        = 5'($urandom_range(0, 3));
            hif.Rs1E        = 5'($urandom_range(0, 3));
            hif.Rs2E        = 5'($urandom_range(0, 3));
            hif.RdE         = 5'($urandom_range(0, 3));
            hif.RdM         = 5'($urandom_range(0, 3));
            hif.RdW         = 5'($urandom_range(0, 3));
            hif.RegWriteM   = 1'($urandom_range(0, 1));
            hif.RegWriteW   = 1'($urandom_range(0, 1));
            hif.ResultSrcE0 = ($urandom_range(0, 2) == 0);
            hif.PCSrcE      = ($urandom_range(0, 4) == 0);
            hif.MemReqM     = ($urandom_range(0, 3) != 0);
            hif.MemReadyM   = ($urandom_range(0, 4) == 0);
            eval();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
